// File: rtl/clock_core.sv
// Alarm clock time core: holds time-of-day and alarm registers in BCD HH:MM,
// advances time on the minute tick and runs the ring/snooze sequencer.
//
// state   | meaning
// IDLE    | alarm armed (if alarmEn), waiting for a time match
// RINGING | alarm sounding; ring counter counts elapsed minutes
// SNOOZE  | alarm silenced; snooze counter counts down to re-ring
module clock_core #(
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] setData,
  input  logic        loadTime,
  input  logic        loadAlarm,
  input  logic        oneMinute,
  input  logic        alarmEn,
  input  logic        stopAlarm,
  input  logic        snooze,
  output logic [15:0] timeData,
  output logic [15:0] alarmData,
  output logic        ringing,
  output logic        dataErr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [3:0] SNOOZE_LD = 4'(SNOOZE_MIN);
  localparam logic [3:0] RING_LIM  = 4'(RING_MIN);

  state_t      state, state_nx;
  logic [3:0]  ring_cnt, ring_cnt_nx;
  logic [3:0]  snz_cnt, snz_cnt_nx;
  logic        set_valid;
  logic        time_ld;
  logic        alarm_ld;
  logic        err_nx;
  logic [15:0] time_inc;
  logic [15:0] time_nx;
  logic        match;

  // Advance a BCD HH:MM word by one minute, wrapping 23:59 to 00:00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [3:0] ht, hu, mt, mu;
    logic       carry;
    {ht, hu, mt, mu} = t;
    carry = 1'b0;
    if (mu == 4'd9) begin
      mu = 4'd0;
      if (mt == 4'd5) begin
        mt = 4'd0;
        carry = 1'b1;
      end else begin
        mt = mt + 4'd1;
      end
    end else begin
      mu = mu + 4'd1;
    end
    if (carry) begin
      if ({ht, hu} == 8'h23) begin
        ht = 4'd0;
        hu = 4'd0;
      end else if (hu == 4'd9) begin
        hu = 4'd0;
        ht = ht + 4'd1;
      end else begin
        hu = hu + 4'd1;
      end
    end
    return {ht, hu, mt, mu};
  endfunction

  // Validate the incoming word and compute next time and the alarm match.
  always_comb begin
    set_valid = (setData[15:12] <= 4'd9) && (setData[11:8] <= 4'd9) &&
                (setData[7:4] <= 4'd5) && (setData[3:0] <= 4'd9) &&
                (setData[15:8] <= 8'h23);
    time_ld  = loadTime & set_valid;
    alarm_ld = loadAlarm & set_valid;
    err_nx   = (loadTime | loadAlarm) & ~set_valid;
    time_inc = bcd_inc(timeData);
    if (time_ld) begin
      time_nx = setData;
    end else if (oneMinute) begin
      time_nx = time_inc;
    end else begin
      time_nx = timeData;
    end
    // Only a tick advance can match; loads (even with a tick) never do.
    match = oneMinute & ~loadTime & alarmEn & (state == IDLE) &
            (time_inc == alarmData);
  end

  // Ring/snooze next-state and counter logic.
  always_comb begin
    state_nx    = state;
    ring_cnt_nx = ring_cnt;
    snz_cnt_nx  = snz_cnt;
    if (!alarmEn || alarm_ld) begin
      state_nx    = IDLE;
      ring_cnt_nx = 4'd0;
      snz_cnt_nx  = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (match) begin
            state_nx    = RINGING;
            ring_cnt_nx = 4'd0;
          end
        end
        RINGING: begin
          if (stopAlarm) begin
            state_nx    = IDLE;
            ring_cnt_nx = 4'd0;
          end else if (snooze) begin
            state_nx    = SNOOZE;
            ring_cnt_nx = 4'd0;
            snz_cnt_nx  = SNOOZE_LD;
          end else if (oneMinute) begin
            if (ring_cnt + 4'd1 >= RING_LIM) begin
              state_nx    = IDLE;
              ring_cnt_nx = 4'd0;
            end else begin
              ring_cnt_nx = ring_cnt + 4'd1;
            end
          end
        end
        SNOOZE: begin
          if (stopAlarm) begin
            state_nx   = IDLE;
            snz_cnt_nx = 4'd0;
          end else if (oneMinute) begin
            snz_cnt_nx = snz_cnt - 4'd1;
            if (snz_cnt <= 4'd1) begin
              state_nx    = RINGING;
              ring_cnt_nx = 4'd0;
              snz_cnt_nx  = 4'd0;
            end
          end
        end
        default: begin
          state_nx    = IDLE;
          ring_cnt_nx = 4'd0;
          snz_cnt_nx  = 4'd0;
        end
      endcase
    end
  end

  // State, counters and all outputs registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ring_cnt  <= 4'd0;
      snz_cnt   <= 4'd0;
      timeData  <= 16'h0000;
      alarmData <= 16'h0000;
      ringing   <= 1'b0;
      dataErr   <= 1'b0;
    end else begin
      state     <= state_nx;
      ring_cnt  <= ring_cnt_nx;
      snz_cnt   <= snz_cnt_nx;
      timeData  <= time_nx;
      if (alarm_ld) alarmData <= setData;
      ringing   <= (state_nx == RINGING);
      dataErr   <= err_nx;
    end
  end

endmodule

// File: tb/tb_clock_core.sv
// Testbench for clock_core: directed scenarios plus randomized traffic,
// checked every cycle against a minutes-of-day reference model.
module tb_clock_core;

  localparam int SNOOZE_MIN = 5;
  localparam int RING_MIN   = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] setData = 16'h0000;
  logic        loadTime = 1'b0;
  logic        loadAlarm = 1'b0;
  logic        oneMinute = 1'b0;
  logic        alarmEn = 1'b0;
  logic        stopAlarm = 1'b0;
  logic        snooze = 1'b0;
  logic [15:0] timeData;
  logic [15:0] alarmData;
  logic        ringing;
  logic        dataErr;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: time as minutes since midnight
  int          m_time;
  logic [15:0] m_alarm;
  int          m_st;       // 0 idle, 1 ringing, 2 snoozing
  int          m_ring_el;
  int          m_snz_left;
  logic        m_err;

  clock_core #(.SNOOZE_MIN(SNOOZE_MIN), .RING_MIN(RING_MIN)) dut (
    .clk(clk), .rst_n(rst_n), .setData(setData), .loadTime(loadTime),
    .loadAlarm(loadAlarm), .oneMinute(oneMinute), .alarmEn(alarmEn),
    .stopAlarm(stopAlarm), .snooze(snooze), .timeData(timeData),
    .alarmData(alarmData), .ringing(ringing), .dataErr(dataErr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] min2bcd(input int m);
    int h, mi;
    h  = m / 60;
    mi = m % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10)};
  endfunction

  function automatic int bcd2min(input logic [15:0] w);
    return (int'(w[15:12]) * 10 + int'(w[11:8])) * 60 + int'(w[7:4]) * 10 + int'(w[3:0]);
  endfunction

  function automatic bit valid_word(input logic [15:0] w);
    return (w[15:12] <= 9) && (w[11:8] <= 9) && (w[7:4] <= 5) && (w[3:0] <= 9) &&
           (bcd2min(w) < 1440);
  endfunction

  task automatic model_reset();
    m_time = 0; m_alarm = 16'h0000; m_st = 0;
    m_ring_el = 0; m_snz_left = 0; m_err = 1'b0;
  endtask

  task automatic model_update();
    bit ok, match;
    int nt;
    ok = valid_word(setData);
    m_err = (loadTime || loadAlarm) && !ok;
    nt = m_time;
    if (loadTime && ok) nt = bcd2min(setData);
    else if (oneMinute) nt = (m_time + 1) % 1440;
    match = oneMinute && !loadTime && alarmEn && (m_st == 0) && (min2bcd(nt) == m_alarm);
    if (!alarmEn || (loadAlarm && ok)) begin
      m_st = 0; m_ring_el = 0; m_snz_left = 0;
    end else if (m_st == 0) begin
      if (match) begin m_st = 1; m_ring_el = 0; end
    end else if (m_st == 1) begin
      if (stopAlarm) begin m_st = 0; m_ring_el = 0; end
      else if (snooze) begin m_st = 2; m_ring_el = 0; m_snz_left = SNOOZE_MIN; end
      else if (oneMinute) begin
        m_ring_el++;
        if (m_ring_el >= RING_MIN) begin m_st = 0; m_ring_el = 0; end
      end
    end else begin
      if (stopAlarm) begin m_st = 0; m_snz_left = 0; end
      else if (oneMinute) begin
        m_snz_left--;
        if (m_snz_left <= 0) begin m_st = 1; m_ring_el = 0; m_snz_left = 0; end
      end
    end
    if (loadAlarm && ok) m_alarm = setData;
    m_time = nt;
  endtask

  task automatic check_model();
    chk("time", timeData, min2bcd(m_time));
    chk("alarm", alarmData, m_alarm);
    chk("ringing", 16'(ringing), 16'(m_st == 1));
    chk("dataErr", 16'(dataErr), 16'(m_err));
  endtask

  // One clock: DUT and model see the same inputs, then outputs are compared
  // on the falling edge and one-cycle strobes are cleared.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_model();
    loadTime = 0; loadAlarm = 0; oneMinute = 0; stopAlarm = 0; snooze = 0;
  endtask

  task automatic load_time(input logic [15:0] w);
    setData = w; loadTime = 1; step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin oneMinute = 1; step(); end
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_time", timeData, 16'h0000);
    chk("rst_ring", 16'(ringing), 16'h0000);
    chk("rst_err", 16'(dataErr), 16'h0000);
    @(negedge clk);
    rst_n = 1;

    // midnight rollover
    load_time(16'h2359);
    chk("ld_2359", timeData, 16'h2359);
    ticks(1);
    chk("wrap", timeData, 16'h0000);
    chk("no_ring_dis", 16'(ringing), 16'h0000);

    // rejected loads
    load_time(16'h1260); chk("err_1260", 16'(dataErr), 16'h0001); chk("hold_1260", timeData, 16'h0000);
    step();              chk("err_clr", 16'(dataErr), 16'h0000);
    load_time(16'h2400); chk("err_2400", 16'(dataErr), 16'h0001);
    step();
    load_time(16'h1A00); chk("err_1A00", 16'(dataErr), 16'h0001); chk("hold_1A00", timeData, 16'h0000);
    step();
    load_time(16'h0909); chk("ld_0909", timeData, 16'h0909); chk("ok_0909", 16'(dataErr), 16'h0000);

    // hour carries
    load_time(16'h0959); ticks(1); chk("carry_10", timeData, 16'h1000);
    load_time(16'h1959); ticks(1); chk("carry_20", timeData, 16'h2000);

    // ring and auto-stop
    alarmEn = 1;
    setData = 16'h0700; loadAlarm = 1; step();
    chk("alarm_ld", alarmData, 16'h0700);
    load_time(16'h0659);
    ticks(1);
    chk("match_time", timeData, 16'h0700);
    chk("match_ring", 16'(ringing), 16'h0001);
    ticks(9);
    chk("ring_9", 16'(ringing), 16'h0001);
    ticks(1);
    chk("ring_timeout", 16'(ringing), 16'h0000);

    // snooze, re-ring, then stop beating snooze
    load_time(16'h0659);
    ticks(2);
    chk("ring_0701", 16'(ringing), 16'h0001);
    snooze = 1; step();
    chk("snoozed", 16'(ringing), 16'h0000);
    ticks(4);
    chk("snooze_4", 16'(ringing), 16'h0000);
    ticks(1);
    chk("rering", 16'(ringing), 16'h0001);
    chk("rering_t", timeData, 16'h0706);
    snooze = 1; stopAlarm = 1; step();
    chk("stop_prio", 16'(ringing), 16'h0000);
    ticks(6);
    chk("no_rering", 16'(ringing), 16'h0000);

    // loads never match; load beats tick
    load_time(16'h0700);
    chk("load_nomatch", 16'(ringing), 16'h0000);
    setData = 16'h0659; loadTime = 1; oneMinute = 1; step();
    chk("load_wins", timeData, 16'h0659);
    ticks(1);
    chk("ring_again", 16'(ringing), 16'h0001);

    // async reset mid-ring
    #2 rst_n = 0;
    #1;
    chk("arst_time", timeData, 16'h0000);
    chk("arst_alarm", alarmData, 16'h0000);
    chk("arst_ring", 16'(ringing), 16'h0000);
    model_reset();
    @(negedge clk);
    rst_n = 1;

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      int r;
      if ($urandom_range(0, 99) < 2) alarmEn = ~alarmEn;
      oneMinute = ($urandom_range(0, 2) == 0);
      loadTime  = ($urandom_range(0, 19) == 0);
      loadAlarm = ($urandom_range(0, 29) == 0);
      stopAlarm = ($urandom_range(0, 39) == 0);
      snooze    = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 3);
      if (r <= 1)      setData = min2bcd($urandom_range(0, 1439));
      else if (r == 2) setData = min2bcd((m_time + $urandom_range(1, 4)) % 1440);
      else             setData = 16'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_core.md
Name: clock_core

Overview:
- Receiving end of the time/alarm set path: owns the running time-of-day and alarm registers for the alarm clock.
- Accepts BCD HH:MM words from the setting logic via load strobes, and advances time on the one-minute tick.
- Publishes timeData/alarmData back to the setting and display logic.
- Runs the alarm ring/snooze state machine.

Parameters:
- SNOOZE_MIN, 5, minutes spent in SNOOZE before re-ringing (1..15).
- RING_MIN, 10, minutes RINGING may last before automatic stop (1..15).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- setData  input  16  BCD word {H tens, H units, M tens, M units}
- loadTime  input  1  1-cycle strobe: write setData into time register
- loadAlarm  input  1  1-cycle strobe: write setData into alarm register
- oneMinute  input  1  1-cycle minute tick from pulse generator
- alarmEn  input  1  alarm enable (level)
- stopAlarm  input  1  1-cycle strobe: cancel ring/snooze
- snooze  input  1  1-cycle strobe: snooze while ringing
- timeData  output  16  current time, BCD HH:MM, registered
- alarmData  output  16  alarm time, BCD HH:MM, registered
- ringing  output  1  high while state = RINGING, registered
- dataErr  output  1  1-cycle pulse: rejected load

Behaviour:
- Reset (async, rst_n low): timeData = 16'h0000, alarmData = 16'h0000, state IDLE, ringing = 0, dataErr = 0, snooze/ring counters = 0.
- Validation, combinational on setData:
  - Valid iff every nibble ≤ 9, hours ≤ 8'h23, minute tens ≤ 5.
  - Invalid load: target register unchanged; dataErr = 1 for exactly one cycle, the cycle after the strobe.
- Loads: valid word appears on timeData/alarmData one cycle after the strobe.
  - loadTime and loadAlarm together: both registers written from the same setData.
  - A valid loadAlarm forces state IDLE and clears the counters.
- Time advance: on oneMinute without loadTime, timeData updates the following cycle.
  - Minute units x9 → 0 with tens + 1; 8'h59 → 8'h00 with hour carry.
  - Hour units 9 → 0 with tens + 1; 8'h23 + carry → 8'h00, so 23:59 → 00:00.
  - loadTime and oneMinute in the same cycle: load wins; that tick is discarded (no advance after the load).
- Alarm match: evaluated on the next-time value of a tick advance only. Loads never trigger a match.
  - If next-time == alarmData, alarmEn = 1 and state = IDLE: state → RINGING on the same edge that updates timeData, so ringing rises together with the matching time.
- State machine (IDLE, RINGING, SNOOZE):
  - IDLE → RINGING on match (above).
  - RINGING → IDLE: stopAlarm, or ring counter reaches RING_MIN. The ring counter counts oneMinute ticks from entry and is cleared on entry.
  - RINGING → SNOOZE: snooze (without stopAlarm). Snooze counter loads SNOOZE_MIN.
  - SNOOZE: each oneMinute decrements the snooze counter. When it reaches 0, state → RINGING and the ring counter clears.
  - SNOOZE → IDLE on stopAlarm.
  - Priority: stopAlarm over snooze. snooze in IDLE or SNOOZE is ignored. stopAlarm in IDLE is ignored.
  - alarmEn low: state forced to IDLE on the next edge, counters cleared. No match while low.
- ringing = (state == RINGING). Time keeps advancing in every state.
- Reset mid-ring or mid-snooze returns to the reset values; there is no residual ring.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then loadTime with setData = 16'h2359, then one oneMinute → timeData 16'h2359 one cycle after load, 16'h0000 after the tick; ringing stays 0 (alarmEn = 0).
- loadTime with 16'h1260, then 16'h2400, then 16'h1A00 → dataErr pulses once per strobe; timeData holds its prior value; a valid 16'h0909 load succeeds with dataErr = 0.
- Hour carry: time 16'h0959 + tick → 16'h1000; time 16'h1959 + tick → 16'h2000.
- alarmEn = 1, alarm 16'h0700, time 16'h0659, tick → timeData 16'h0700 and ringing = 1 on the same edge; after 10 ticks with no input, ringing = 0.
- While ringing, pulse snooze → ringing 0; after 5 ticks → ringing 1 at 16'h0706. Then snooze and stopAlarm in the same cycle → IDLE; no re-ring after a further 5 ticks.
- loadTime with 16'h0700 (alarm = 16'h0700) → no ring. loadTime and oneMinute in the same cycle with 16'h0659 → timeData 16'h0659, no advance. Assert rst_n low during RINGING → all outputs 0 immediately.
